// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions: character width and the state
//                encoding of the byte feeder FSM (also used by the rx drain).
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Width of one UART character.
    localparam int UART_DATA_W = 8;

    // Feeder FSM state encoding.
    typedef logic [1:0] feeder_state_t;

    localparam feeder_state_t c_st_idle      = 2'd0;
    localparam feeder_state_t c_st_load      = 2'd1;
    localparam feeder_state_t c_st_wait_ack  = 2'd2;
    localparam feeder_state_t c_st_wait_done = 2'd3;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO with extra-MSB pointers. Read data is the
//                current head (combinational from storage); a push is only
//                visible at the head from the following cycle.
//  Ports       : clk, reset_n (async active-low)
//                push / push_data   - write request (ignored when full)
//                pop  / pop_data    - read request (ignored when empty), head
//                full / empty       - status flags
//                level              - entries stored, 0..DEPTH
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo
    import uart_pkg::*;
#(
    parameter  int DATA_W  = UART_DATA_W,
    parameter  int DEPTH   = 8,
    localparam int ADDR_W  = $clog2(DEPTH),
    localparam int LEVEL_W = ADDR_W + 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               push,
    input  logic [DATA_W-1:0]  push_data,
    input  logic               pop,
    output logic [DATA_W-1:0]  pop_data,
    output logic               full,
    output logic               empty,
    output logic [LEVEL_W-1:0] level
);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [LEVEL_W-1:0] r_wr_ptr;
    logic [LEVEL_W-1:0] r_rd_ptr;

    logic               w_push_ok;
    logic               w_pop_ok;

    // Pointers carry one extra bit so that full and empty are distinguishable
    // when the address bits match.
    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                       (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
    assign level     = r_wr_ptr - r_rd_ptr;
    assign pop_data  = r_mem[r_rd_ptr[ADDR_W-1:0]];

    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + LEVEL_W'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + LEVEL_W'(1);
            end
        end
    end

    // Storage needs no reset: the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= push_data;
        end
    end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/uart_tx_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_feeder
//  Description : Buffers a valid/ready byte stream and feeds the UART
//                transmitter one byte at a time, issuing a load strobe only
//                while the UART holding register is empty and following each
//                byte until the UART reports it done.
//  Ports       : clk, reset_n (async active-low)
//                enable              - allow new loads; mirrored to tx_enable
//                s_valid/s_data      - upstream byte, s_ready = FIFO not full
//                ld_tx_data/tx_data  - load strobe and byte to the UART
//                tx_enable           - UART transmit enable (enable, 1 cycle late)
//                tx_empty            - UART holding register empty
//                fifo_level          - bytes buffered, 0..DEPTH
//                busy                - a byte is being handed to the UART
//                ack_err             - sticky: UART ignored a load strobe
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter  int DEPTH       = 8,
    parameter  int ACK_TIMEOUT = 4,
    localparam int LEVEL_W     = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   s_valid,
    input  logic [UART_DATA_W-1:0] s_data,
    output logic                   s_ready,
    output logic                   ld_tx_data,
    output logic [UART_DATA_W-1:0] tx_data,
    output logic                   tx_enable,
    input  logic                   tx_empty,
    output logic [LEVEL_W-1:0]     fifo_level,
    output logic                   busy,
    output logic                   ack_err
);

    localparam int c_cnt_w = $clog2(ACK_TIMEOUT) + 1;

    // The timeout fires in the WAIT_ACK cycle in which the counter would step
    // to ACK_TIMEOUT-1, so ack_err is visible exactly ACK_TIMEOUT cycles
    // after the load strobe.
    localparam logic [c_cnt_w-1:0] c_ack_last = c_cnt_w'(ACK_TIMEOUT - 2);

    // ------------------------------------------------------------------
    // Byte buffer
    // ------------------------------------------------------------------
    logic                   w_fifo_push;
    logic                   w_fifo_pop;
    logic [UART_DATA_W-1:0] w_fifo_head;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;

    assign s_ready     = !w_fifo_full;
    assign w_fifo_push = s_valid && s_ready;

    sync_fifo #(
        .DATA_W (UART_DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (w_fifo_push),
        .push_data (s_data),
        .pop       (w_fifo_pop),
        .pop_data  (w_fifo_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .level     (fifo_level)
    );

    // ------------------------------------------------------------------
    // FSM state and datapath registers
    // ------------------------------------------------------------------
    feeder_state_t          r_state;
    feeder_state_t          w_next_state;
    logic [c_cnt_w-1:0]     r_ack_cnt;
    logic [UART_DATA_W-1:0] r_tx_data;
    logic                   r_tx_enable;
    logic                   r_ack_err;

    logic                   w_load_start;
    logic                   w_cnt_clr;
    logic                   w_cnt_inc;
    logic                   w_set_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load_start = 1'b0;
        w_fifo_pop   = 1'b0;
        w_cnt_clr    = 1'b0;
        w_cnt_inc    = 1'b0;
        w_set_err    = 1'b0;
        ld_tx_data   = 1'b0;

        case (r_state)
            c_st_idle: begin
                if (enable && !w_fifo_empty && tx_empty) begin
                    w_next_state = c_st_load;
                    w_load_start = 1'b1;
                end
            end

            c_st_load: begin
                // tx_data was captured on entry, so it is already valid while
                // the strobe is high; the head is released in this cycle.
                ld_tx_data   = 1'b1;
                w_fifo_pop   = 1'b1;
                w_cnt_clr    = 1'b1;
                w_next_state = c_st_wait_ack;
            end

            c_st_wait_ack: begin
                if (!tx_empty) begin
                    w_next_state = c_st_wait_done;
                end else if (r_ack_cnt == c_ack_last) begin
                    // UART never took the byte: flag it and drop the byte.
                    w_set_err    = 1'b1;
                    w_next_state = c_st_idle;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end

            c_st_wait_done: begin
                if (tx_empty) begin
                    w_next_state = c_st_idle;
                end
            end

            default: begin
                w_next_state = c_st_idle;
            end
        endcase
    end

    // Acknowledge timeout counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ack_cnt <= '0;
        end else if (w_cnt_clr) begin
            r_ack_cnt <= '0;
        end else if (w_cnt_inc) begin
            r_ack_cnt <= r_ack_cnt + c_cnt_w'(1);
        end
    end

    // Byte to the UART: captured when leaving IDLE, held until the next load.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_data <= '0;
        end else if (w_load_start) begin
            r_tx_data <= w_fifo_head;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_enable <= 1'b0;
            r_ack_err   <= 1'b0;
        end else begin
            r_tx_enable <= enable;
            r_ack_err   <= r_ack_err | w_set_err;
        end
    end

    assign tx_data   = r_tx_data;
    assign tx_enable = r_tx_enable;
    assign ack_err   = r_ack_err;
    assign busy      = (r_state != c_st_idle);

endmodule : uart_tx_feeder
`default_nettype wire

// File: tb/tb_uart_tx_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_feeder
//  Description : Self-checking bench for uart_tx_feeder with a behavioural
//                UART model, a byte scoreboard and a buffer occupancy model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_feeder;

    localparam int DEPTH       = 8;
    localparam int ACK_TIMEOUT = 4;
    localparam int LEVEL_W     = $clog2(DEPTH) + 1;

    localparam int U_NORMAL = 0;   // takes a load, busy for frame_len cycles
    localparam int U_IGNORE = 1;   // never acknowledges a load
    localparam int U_HOLD   = 2;   // stays busy (tx_empty low)

    logic               clk      = 1'b0;
    logic               reset_n  = 1'b0;
    logic               enable   = 1'b0;
    logic               s_valid  = 1'b0;
    logic [7:0]         s_data   = 8'h00;
    logic               tx_empty = 1'b1;
    logic               s_ready;
    logic               ld_tx_data;
    logic [7:0]         tx_data;
    logic               tx_enable;
    logic [LEVEL_W-1:0] fifo_level;
    logic               busy;
    logic               ack_err;

    always #5 clk = ~clk;

    uart_tx_feeder #(
        .DEPTH       (DEPTH),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .ld_tx_data (ld_tx_data),
        .tx_data    (tx_data),
        .tx_enable  (tx_enable),
        .tx_empty   (tx_empty),
        .fifo_level (fifo_level),
        .busy       (busy),
        .ack_err    (ack_err)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // UART model
    // ------------------------------------------------------------------
    int uart_mode = U_NORMAL;
    int frame_len = 5;
    int u_cnt     = 0;

    always @(posedge clk) begin
        if (uart_mode == U_HOLD) begin
            tx_empty <= 1'b0;
            u_cnt    <= 0;
        end else if (uart_mode == U_IGNORE) begin
            tx_empty <= 1'b1;
            u_cnt    <= 0;
        end else if (ld_tx_data && tx_empty) begin
            tx_empty <= 1'b0;
            u_cnt    <= frame_len;
        end else if (u_cnt > 1) begin
            u_cnt <= u_cnt - 1;
        end else begin
            u_cnt    <= 0;
            tx_empty <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard and occupancy model, sampled mid-cycle
    // ------------------------------------------------------------------
    logic [7:0] exp_q[$];
    int         model_level = 0;
    int         strobes     = 0;
    int         last_ld_cyc = -100;
    logic       prev_en     = 1'b0;
    logic [7:0] last_tx     = 8'h00;

    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
            model_level = 0;
            last_ld_cyc = -100;
            prev_en     = 1'b0;
            last_tx     = 8'h00;
        end else begin
            chk("fifo_level", fifo_level, model_level);
            chk("s_ready", s_ready, model_level < DEPTH);
            chk("tx_enable", tx_enable, prev_en);
            if (ld_tx_data) begin
                strobes++;
                chk("strobe_has_byte", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    chk("tx_data_order", tx_data, exp_q[0]);
                    void'(exp_q.pop_front());
                end
                chk("strobe_gap", (cyc - last_ld_cyc) >= 2, 1);
                last_ld_cyc = cyc;
                last_tx     = tx_data;
            end else begin
                chk("tx_data_hold", tx_data, last_tx);
            end
            if (s_valid && s_ready) begin
                exp_q.push_back(s_data);
                model_level++;
            end
            if (ld_tx_data) begin
                model_level--;
            end
            prev_en = enable;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        s_valid = 1'b0;
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(1);
    endtask

    task automatic push_byte(input logic [7:0] d);
        int t;
        t       = 0;
        s_valid = 1'b1;
        s_data  = d;
        while (!s_ready && t < 200) begin
            tick(1);
            t++;
        end
        chk("push_accept", s_ready, 1);
        tick(1);
        s_valid = 1'b0;
    endtask

    task automatic wait_strobe(input int start, input int limit);
        int t;
        t = 0;
        while (strobes == start && t < limit) begin
            tick(1);
            t++;
        end
        chk("strobe_seen", strobes != start, 1);
    endtask

    task automatic wait_drain(input int limit);
        int t;
        t = 0;
        while ((busy || fifo_level != 0) && t < limit) begin
            tick(1);
            t++;
        end
        chk("drain_done", !busy && fifo_level == 0, 1);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ld"},      ld_tx_data, 0);
        chk({tag, "_txdata"},  tx_data,    8'h00);
        chk({tag, "_txen"},    tx_enable,  0);
        chk({tag, "_sready"},  s_ready,    1);
        chk({tag, "_busy"},    busy,       0);
        chk({tag, "_ackerr"},  ack_err,    0);
        chk({tag, "_level"},   fifo_level, 0);
    endtask

    typedef struct {
        int         n_push;
        logic [7:0] base;
        int         exp_level;
        logic       exp_ready;
    } fill_vec_t;

    fill_vec_t vecs[5];

    initial begin
        int s0;
        int s1;
        int n_cyc;
        int l_cyc;
        int acc;
        int sent;
        int t;

        vecs[0] = '{1,  8'h10, 1, 1'b1};
        vecs[1] = '{3,  8'h20, 3, 1'b1};
        vecs[2] = '{7,  8'h30, 7, 1'b1};
        vecs[3] = '{8,  8'h00, 8, 1'b0};
        vecs[4] = '{10, 8'h00, 8, 1'b0};

        // Reset values while reset is held.
        tick(2);
        check_reset_vals("rst0");
        reset_n = 1'b1;
        tick(1);

        // Single byte: strobe two cycles after the push cycle.
        enable = 1'b1;
        tick(1);
        s0      = strobes;
        s_valid = 1'b1;
        s_data  = 8'hA5;
        n_cyc   = cyc;
        tick(1);
        s_valid = 1'b0;
        wait_strobe(s0, 10);
        chk("single_latency", last_ld_cyc - n_cyc, 2);
        chk("single_data", tx_data, 8'hA5);
        chk("single_busy", busy, 1);
        wait_drain(50);
        chk("single_done_empty", tx_empty, 1);

        // Fill patterns with the UART held busy, then drained in order.
        for (int i = 0; i < 5; i++) begin
            do_reset();
            uart_mode = U_HOLD;
            enable    = 1'b1;
            tick(2);
            acc = 0;
            for (int k = 0; k < vecs[i].n_push; k++) begin
                s_valid = 1'b1;
                s_data  = vecs[i].base + 8'(k);
                if (s_ready) acc++;
                tick(1);
            end
            s_valid = 1'b0;
            tick(1);
            chk("fill_accepted", acc, vecs[i].exp_level);
            chk("fill_level", fifo_level, vecs[i].exp_level);
            chk("fill_ready", s_ready, vecs[i].exp_ready);
            chk("fill_no_load", busy, 0);
            s0        = strobes;
            uart_mode = U_NORMAL;
            frame_len = 3;
            wait_drain(400);
            chk("fill_strobes", strobes - s0, vecs[i].exp_level);
            chk("fill_all_sent", exp_q.size(), 0);
        end

        // Acknowledge timeout: UART ignores the strobe.
        do_reset();
        uart_mode = U_IGNORE;
        enable    = 1'b1;
        tick(1);
        s0 = strobes;
        push_byte(8'h3C);
        wait_strobe(s0, 20);
        l_cyc = last_ld_cyc;
        while (cyc < l_cyc + ACK_TIMEOUT - 1) tick(1);
        chk("ack_err_early", ack_err, 0);
        chk("ack_busy_early", busy, 1);
        tick(1);
        chk("ack_err_set", ack_err, 1);
        chk("ack_back_idle", busy, 0);
        uart_mode = U_NORMAL;
        frame_len = 4;
        s0 = strobes;
        push_byte(8'hC3);
        wait_strobe(s0, 20);
        chk("ack_next_data", tx_data, 8'hC3);
        chk("ack_err_sticky", ack_err, 1);
        wait_drain(50);

        // Reset mid-stream with three bytes queued behind an active byte.
        frame_len = 12;
        push_byte(8'h50);
        push_byte(8'h51);
        push_byte(8'h52);
        push_byte(8'h53);
        chk("pre_rst_level", fifo_level, 3);
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_ackerr", ack_err, 1);
        reset_n = 1'b0;
        #1;
        check_reset_vals("rst_mid");
        tick(2);
        reset_n = 1'b1;
        s0 = strobes;
        tick(20);
        chk("post_rst_no_strobe", strobes - s0, 0);
        chk("post_rst_level", fifo_level, 0);
        chk("post_rst_busy", busy, 0);

        // Enable gating during WAIT_DONE.
        do_reset();
        uart_mode = U_NORMAL;
        frame_len = 6;
        enable    = 1'b1;
        s0 = strobes;
        push_byte(8'h40);
        push_byte(8'h41);
        push_byte(8'h42);
        wait_strobe(s0, 20);
        while (cyc < last_ld_cyc + 2) tick(1);
        chk("gate_busy", busy, 1);
        chk("gate_level", fifo_level, 2);
        enable = 1'b0;
        chk("gate_txen_still", tx_enable, 1);
        tick(1);
        chk("gate_txen_low", tx_enable, 0);
        s1 = strobes;
        tick(frame_len + 6);
        chk("gate_no_strobe", strobes - s1, 0);
        chk("gate_idle", busy, 0);
        chk("gate_kept", fifo_level, 2);
        enable = 1'b1;
        wait_drain(100);
        chk("gate_resumed", strobes - s1, 2);
        chk("gate_all_sent", exp_q.size(), 0);

        // Random stream with random valid and random UART frame lengths.
        do_reset();
        uart_mode = U_NORMAL;
        enable    = 1'b1;
        s0   = strobes;
        sent = 0;
        t    = 0;
        while (sent < 20 && t < 3000) begin
            frame_len = $urandom_range(1, 10);
            s_valid   = 1'($urandom_range(0, 1));
            s_data    = 8'($urandom);
            if (s_valid && s_ready) sent++;
            tick(1);
            t++;
        end
        s_valid = 1'b0;
        chk("rand_sent", sent, 20);
        wait_drain(2000);
        chk("rand_strobes", strobes - s0, 20);
        chk("rand_all_sent", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, actual timeout, expected completion");
        $fatal(1);
    end

endmodule : tb_uart_tx_feeder
`default_nettype wire
